vfwd_scoreboard: RTL and testbench

VFWD_SCOREBOARD -- requirements
Module: vfwd_scoreboard

---
 rtl/vfwd_pkg.sv | 20 ++
 rtl/vfwd_opmux.sv | 48 ++++
 rtl/vfwd_scoreboard.sv | 153 +++++++++++++++
 tb/tb_vfwd_scoreboard.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/vfwd_pkg.sv
// Shared defaults and the operand-source encoding for the vector forwarding scoreboard.
package vfwd_pkg;

  localparam int VFWD_VLEN = 64;
  localparam int VFWD_NREG = 32;
  localparam int VFWD_LATW = 4;

  // Where a forwarded operand comes from
  typedef enum logic [1:0] {
    SEL_RF  = 2'd0,
    SEL_EX  = 2'd1,
    SEL_MEM = 2'd2
  } vfwd_sel_e;

  // True when a pipeline stage holds a qualified write to the given register
  function automatic logic stage_hit(input logic valid, input logic wen, input logic match);
    return valid & wen & match;
  endfunction

endpackage

// File: rtl/vfwd_opmux.sv
// Per-operand forwarding mux: the younger EX/MEM result wins over MEM/WB,
// which wins over the register file. Purely combinational.
module vfwd_opmux
  import vfwd_pkg::*;
#(
  parameter int VLEN = VFWD_VLEN,
  parameter int RW   = 5
) (
  input  logic [RW-1:0]   rs,
  input  logic [VLEN-1:0] rdv,
  input  logic            ex_valid,
  input  logic            ex_wen,
  input  logic [RW-1:0]   ex_vrd,
  input  logic [VLEN-1:0] ex_res,
  input  logic            mem_valid,
  input  logic            mem_wen,
  input  logic [RW-1:0]   mem_vrd,
  input  logic [VLEN-1:0] mem_res,
  output logic [VLEN-1:0] op,
  output vfwd_sel_e       sel
);

  logic ex_hit_s;
  logic mem_hit_s;

  // Detect qualified stage matches against this source register
  always_comb begin
    ex_hit_s  = stage_hit(ex_valid, ex_wen, (ex_vrd == rs));
    mem_hit_s = stage_hit(mem_valid, mem_wen, (mem_vrd == rs));
  end

  // Priority select: EX over MEM over register file
  always_comb begin
    op  = rdv;
    sel = SEL_RF;
    if (ex_hit_s) begin
      op  = ex_res;
      sel = SEL_EX;
    end else if (mem_hit_s) begin
      op  = mem_res;
      sel = SEL_MEM;
    end else begin
      op  = rdv;
      sel = SEL_RF;
    end
  end

endmodule

// File: rtl/vfwd_scoreboard.sv
// Vector register scoreboard with operand forwarding.
// Tracks per-register busy/countdown state, raises id_stall on RAW hazards whose
// result is not yet forwardable and on WAW hazards that would complete out of
// order, and forwards EX/MEM or MEM/WB results to the two operands.
// Optional feature: define VFWD_STATS_EN to build the saturating stall counter;
// otherwise stall_cnt is tied to zero.
module vfwd_scoreboard
  import vfwd_pkg::*;
#(
  parameter  int VLEN = VFWD_VLEN,
  parameter  int NREG = VFWD_NREG,
  parameter  int LATW = VFWD_LATW,
  localparam int RW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [RW-1:0]   id_vrs1,
  input  logic [RW-1:0]   id_vrs2,
  input  logic [RW-1:0]   id_vrd,
  input  logic            id_wen,
  input  logic [LATW-1:0] id_lat,
  output logic            id_stall,
  input  logic [VLEN-1:0] rdvA,
  input  logic [VLEN-1:0] rdvB,
  input  logic            ex_valid,
  input  logic            ex_wen,
  input  logic [RW-1:0]   ex_vrd,
  input  logic [VLEN-1:0] ex_res,
  input  logic            mem_valid,
  input  logic            mem_wen,
  input  logic [RW-1:0]   mem_vrd,
  input  logic [VLEN-1:0] mem_res,
  output logic [VLEN-1:0] opA,
  output logic [VLEN-1:0] opB,
  output logic [1:0]      selA,
  output logic [1:0]      selB,
  output logic [31:0]     stall_cnt
);

  localparam logic [LATW-1:0] CNT_ZERO = {LATW{1'b0}};
  localparam logic [LATW-1:0] CNT_ONE  = {{(LATW-1){1'b0}}, 1'b1};

  logic [NREG-1:0] busy_q, busy_d;
  logic [LATW-1:0] cnt_q [NREG];
  logic [LATW-1:0] cnt_d [NREG];

  logic      raw_a_s, raw_b_s, waw_s, stall_s, issue_s, clear_s;
  vfwd_sel_e sel_a_s, sel_b_s;

  // Hazard detection; busy alone is not a hazard once the countdown has
  // expired, because the result is then reachable through forwarding
  always_comb begin
    raw_a_s = busy_q[id_vrs1] & (cnt_q[id_vrs1] != CNT_ZERO);
    raw_b_s = busy_q[id_vrs2] & (cnt_q[id_vrs2] != CNT_ZERO);
    waw_s   = id_wen & busy_q[id_vrd] & (cnt_q[id_vrd] > id_lat);
    stall_s = id_valid & (raw_a_s | raw_b_s | waw_s);
    issue_s = id_valid & ~stall_s & id_wen;
    clear_s = stage_hit(mem_valid, mem_wen, 1'b1);
  end

  assign id_stall = stall_s;

  // Next scoreboard state: countdown, writeback clear, issue, then flush on top
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREG; r++) begin
      if (cnt_q[r] != CNT_ZERO) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end else begin
        cnt_d[r] = CNT_ZERO;
      end
    end
    if (clear_s) begin
      busy_d[mem_vrd] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    // Issue is applied after the clear so it wins on the same register
    if (issue_s) begin
      busy_d[id_vrd] = 1'b1;
      cnt_d[id_vrd]  = id_lat;
    end else begin
      busy_d = busy_d;
    end
    if (flush) begin
      busy_d = {NREG{1'b0}};
      for (int r = 0; r < NREG; r++) begin
        cnt_d[r] = CNT_ZERO;
      end
    end else begin
      busy_d = busy_d;
    end
  end

  // Scoreboard state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= {NREG{1'b0}};
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= CNT_ZERO;
      end
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  vfwd_opmux #(.VLEN(VLEN), .RW(RW)) u_opmux_a (
    .rs(id_vrs1), .rdv(rdvA),
    .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_vrd(ex_vrd), .ex_res(ex_res),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_vrd(mem_vrd), .mem_res(mem_res),
    .op(opA), .sel(sel_a_s)
  );

  vfwd_opmux #(.VLEN(VLEN), .RW(RW)) u_opmux_b (
    .rs(id_vrs2), .rdv(rdvB),
    .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_vrd(ex_vrd), .ex_res(ex_res),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_vrd(mem_vrd), .mem_res(mem_res),
    .op(opB), .sel(sel_b_s)
  );

  assign selA = sel_a_s;
  assign selB = sel_b_s;

`ifdef VFWD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles; flush leaves it alone
  always_comb begin
    if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_vfwd_scoreboard.sv
// Directed self-checking bench for vfwd_scoreboard (default parameters).
module tb_vfwd_scoreboard;

`ifdef VFWD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, id_valid, id_wen, id_stall;
  logic [4:0]  id_vrs1, id_vrs2, id_vrd;
  logic [3:0]  id_lat;
  logic [63:0] rdvA, rdvB, ex_res, mem_res, opA, opB;
  logic        ex_valid, ex_wen, mem_valid, mem_wen;
  logic [4:0]  ex_vrd, mem_vrd;
  logic [1:0]  selA, selB;
  logic [31:0] stall_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_sc = 0;

  vfwd_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_vrs1(id_vrs1), .id_vrs2(id_vrs2), .id_vrd(id_vrd),
    .id_wen(id_wen), .id_lat(id_lat), .id_stall(id_stall),
    .rdvA(rdvA), .rdvB(rdvB),
    .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_vrd(ex_vrd), .ex_res(ex_res),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_vrd(mem_vrd), .mem_res(mem_res),
    .opA(opA), .opB(opB), .selA(selA), .selB(selB), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_stages();
    ex_valid = 1'b0; ex_wen = 1'b0; ex_vrd = 5'd0; ex_res = 64'd0;
    mem_valid = 1'b0; mem_wen = 1'b0; mem_vrd = 5'd0; mem_res = 64'd0;
  endtask

  task automatic id_set(input logic v, input logic w, input logic [4:0] rd,
                        input logic [3:0] lat, input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid = v; id_wen = w; id_vrd = rd; id_lat = lat; id_vrs1 = rs1; id_vrs2 = rs2;
  endtask

  function automatic logic [63:0] exp_stats();
    return STATS ? 64'(exp_sc) : 64'd0;
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    rdvA = 64'h1111_0000_AAAA_0001; rdvB = 64'h2222_0000_BBBB_0002;
    idle_stages();
    id_set(1'b1, 1'b0, 5'd0, 4'd0, 5'd3, 5'd4);
    #2;
    // reset state
    chk("rst_stall", {63'd0, id_stall}, 64'd0);
    chk("rst_opA", opA, 64'h1111_0000_AAAA_0001);
    chk("rst_selA", {62'd0, selA}, 64'd0);
    chk("rst_stall_cnt", {32'd0, stall_cnt}, 64'd0);
    #6 rst_n = 1'b1;
    tick();

    // RAW countdown: issue vrd=3 lat=2
    id_set(1'b1, 1'b1, 5'd3, 4'd2, 5'd0, 5'd1);
    #1 chk("raw_issue_nostall", {63'd0, id_stall}, 64'd0);
    tick();
    id_set(1'b1, 1'b0, 5'd10, 4'd0, 5'd3, 5'd1);
    #1 chk("raw_stall_c1", {63'd0, id_stall}, 64'd1);
    exp_sc++;
    tick();
    #1 chk("raw_stall_c2", {63'd0, id_stall}, 64'd1);
    exp_sc++;
    tick();
    ex_valid = 1'b1; ex_wen = 1'b1; ex_vrd = 5'd3; ex_res = 64'hC0DE;
    #1 chk("raw_release", {63'd0, id_stall}, 64'd0);
    chk("raw_selA_ex", {62'd0, selA}, 64'd1);
    chk("raw_opA_ex", opA, 64'hC0DE);
    chk("raw_stall_cnt", {32'd0, stall_cnt}, exp_stats());
    tick();

    // EX beats MEM on the same register
    id_set(1'b0, 1'b0, 5'd0, 4'd0, 5'd0, 5'd5);
    ex_valid = 1'b1; ex_wen = 1'b1; ex_vrd = 5'd5; ex_res = 64'hAAAA;
    mem_valid = 1'b1; mem_wen = 1'b1; mem_vrd = 5'd5; mem_res = 64'hBBBB;
    #1 chk("prio_opB", opB, 64'hAAAA);
    chk("prio_selB", {62'd0, selB}, 64'd1);
    chk("prio_opA_rf", opA, 64'h1111_0000_AAAA_0001);
    chk("prio_selA_rf", {62'd0, selA}, 64'd0);
    // unqualified EX ignored, MEM used
    ex_vrd = 5'd7; ex_wen = 1'b0; mem_vrd = 5'd7; mem_res = 64'h1234; id_vrs1 = 5'd7;
    #1 chk("unq_ex_opA", opA, 64'h1234);
    chk("unq_ex_selA", {62'd0, selA}, 64'd2);
    // invalid stages ignored
    ex_wen = 1'b1; ex_valid = 1'b0; mem_valid = 1'b0;
    #1 chk("unq_all_opA", opA, 64'h1111_0000_AAAA_0001);
    chk("unq_all_selA", {62'd0, selA}, 64'd0);
    // register 0 forwards like any other
    ex_valid = 1'b1; ex_vrd = 5'd0; ex_res = 64'h0F0F; id_vrs2 = 5'd0;
    #1 chk("reg0_opB", opB, 64'h0F0F);
    chk("reg0_selB", {62'd0, selB}, 64'd1);
    idle_stages();
    tick();

    // WAW: reg 4 cnt=5, then issue vrd=4 lat=1
    id_set(1'b1, 1'b1, 5'd4, 4'd5, 5'd1, 5'd2);
    #1 chk("waw_first_issue", {63'd0, id_stall}, 64'd0);
    tick();
    id_set(1'b1, 1'b1, 5'd4, 4'd1, 5'd1, 5'd2);
    for (int c = 5; c >= 2; c--) begin
      #1 chk($sformatf("waw_stall_cnt%0d", c), {63'd0, id_stall}, 64'd1);
      exp_sc++;
      tick();
    end
    #1 chk("waw_release_eq", {63'd0, id_stall}, 64'd0);
    tick();
    id_set(1'b1, 1'b0, 5'd0, 4'd0, 5'd4, 5'd2);
    #1 chk("waw_reissued_raw", {63'd0, id_stall}, 64'd1);
    exp_sc++;
    tick();
    #1 chk("waw_reissued_done", {63'd0, id_stall}, 64'd0);
    tick();

    // issue beats a same-cycle writeback clear
    id_set(1'b1, 1'b1, 5'd6, 4'd3, 5'd1, 5'd2);
    mem_valid = 1'b1; mem_wen = 1'b1; mem_vrd = 5'd6;
    tick();
    idle_stages();
    id_set(1'b1, 1'b0, 5'd0, 4'd0, 5'd6, 5'd2);
    #1 chk("issue_over_clear", {63'd0, id_stall}, 64'd1);
    exp_sc++;
    tick();
    // writeback clear while counting; id_valid=0 keeps stall low
    id_valid = 1'b0;
    mem_valid = 1'b1; mem_wen = 1'b1; mem_vrd = 5'd6;
    #1 chk("novalid_nostall", {63'd0, id_stall}, 64'd0);
    tick();
    idle_stages();
    id_valid = 1'b1;
    #1 chk("clear_busy", {63'd0, id_stall}, 64'd0);
    tick();

    // flush drops pending writes and the same-cycle issue
    id_set(1'b1, 1'b1, 5'd9, 4'd3, 5'd1, 5'd2);
    tick();
    flush = 1'b1;
    id_set(1'b1, 1'b1, 5'd11, 4'd4, 5'd1, 5'd2);
    tick();
    flush = 1'b0;
    id_set(1'b1, 1'b0, 5'd0, 4'd0, 5'd9, 5'd11);
    #1 chk("flush_nostall", {63'd0, id_stall}, 64'd0);
    chk("flush_stall_cnt", {32'd0, stall_cnt}, exp_stats());
    tick();

    // async reset mid-countdown
    id_set(1'b1, 1'b1, 5'd12, 4'd7, 5'd1, 5'd2);
    tick();
    id_set(1'b1, 1'b0, 5'd0, 4'd0, 5'd12, 5'd2);
    #1 chk("pre_rst_stall", {63'd0, id_stall}, 64'd1);
    rst_n = 1'b0;
    exp_sc = 0;
    #1 chk("async_rst_stall", {63'd0, id_stall}, 64'd0);
    chk("async_rst_cnt", {32'd0, stall_cnt}, 64'd0);
    chk("async_rst_opA", opA, 64'h1111_0000_AAAA_0001);
    #1 rst_n = 1'b1;
    tick();
    #1 chk("post_rst_stall", {63'd0, id_stall}, 64'd0);
    chk("post_rst_cnt", {32'd0, stall_cnt}, exp_stats());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
